msx_bus_event_fifo: RTL and testbench

Captures completed MSX bus cycles addressed to the cartridge (slot memory cycles and I/O cycles) and queues them for the Raspberry Pi. The Pi drains the queue over a 16-bit word port using a four-phase req/ack handshake. The block sits between the MSX bus sampling logic and the Pi-side command port, and replaces polling of the single-entry address/data latch. Every Pi read of an event is therefore lossless up to DEPTH queued cycles.

---
 rtl/msx_bus_event_fifo_if.sv | 30 +++
 rtl/msx_bus_event_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_msx_bus_event_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msx_bus_event_fifo_if.sv
// Port bundle for msx_bus_event_fifo: the MSX bus sample on one side and the
// Pi-side word port on the other.
interface msx_bus_event_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [15:0]         a;
    logic [7:0]          d_in;
    logic                rd;
    logic                wr;
    logic                mreq;
    logic                iorq;
    logic                sltsl;
    logic                pi_req;
    logic                pi_sel;
    logic                ovf_clr;
    logic [15:0]         pi_data;
    logic                pi_ack;
    logic                atn;
    logic [DEPTH_LOG2:0] level;

    modport master (
        output a, d_in, rd, wr, mreq, iorq, sltsl, pi_req, pi_sel, ovf_clr,
        input  pi_data, pi_ack, atn, level
    );

    modport slave (
        input  a, d_in, rd, wr, mreq, iorq, sltsl, pi_req, pi_sel, ovf_clr,
        output pi_data, pi_ack, atn, level
    );
endinterface

// File: rtl/msx_bus_event_fifo.sv
// Captures completed MSX cartridge bus cycles (slot memory and I/O) into a
// circular queue that the Raspberry Pi drains over a four-phase req/ack port.
module msx_bus_event_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic                 clk,
    input logic                 reset,
    msx_bus_event_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } hs_state_t;

    // Entry layout: [25:10] addr, [9] kind, [8] dir, [7:0] data.
    function automatic logic [15:0] status_word(input logic [9:0] entry_lo,
                                                input logic ovf,
                                                input logic empty);
        logic [15:0] w;
        if (empty) begin
            w = {2'b00, ovf, 1'b1, 4'h0, 8'hFF};
        end else begin
            w = {entry_lo[8], entry_lo[9], ovf, 1'b0, 4'h0, entry_lo[7:0]};
        end
        return w;
    endfunction

    logic              rd_q_r, wr_q_r;
    logic [7:0]        d_q_r;
    logic [15:0]       addr_lat_r;
    logic              kind_lat_r, dir_lat_r, busy_r;
    logic [25:0]       mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, level_r;
    logic              atn_r, ovf_r;
    hs_state_t         state_r, state_nxt_s;
    logic [15:0]       pi_data_r;
    logic              pi_ack_r, lat_sel_r, lat_nonempty_r;

    logic              sel_s, st_s, st_q_s, start_s, push_s;
    logic              empty_s, full_s, pop_s, latch_s, wr_en_s, drop_s;
    logic [PW-1:0]     wr_ptr_nxt_s, rd_ptr_nxt_s, level_nxt_s;
    logic [25:0]       head_s;
    logic [15:0]       pi_word_s;

    assign sel_s   = (!bus.sltsl && !bus.mreq) || !bus.iorq;
    assign st_s    = bus.rd & bus.wr;
    assign st_q_s  = rd_q_r & wr_q_r;
    assign start_s = st_q_s && !st_s && sel_s;
    assign push_s  = busy_r && st_s;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                     (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
    assign head_s  = mem_r[rd_ptr_r[PW-2:0]];

    // Bus strobe history and per-cycle address/kind/dir capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q_r     <= 1'b1;
            wr_q_r     <= 1'b1;
            d_q_r      <= 8'h00;
            addr_lat_r <= 16'h0000;
            kind_lat_r <= 1'b0;
            dir_lat_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            rd_q_r <= bus.rd;
            wr_q_r <= bus.wr;
            d_q_r  <= bus.d_in;
            if (start_s) begin
                addr_lat_r <= bus.a;
                kind_lat_r <= ~bus.iorq;
                dir_lat_r  <= ~bus.rd;
                busy_r     <= 1'b1;
            end else if (push_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Next pointer values; a push into a full queue only lands if a pop frees the slot.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_en_s      = 1'b0;
        drop_s       = 1'b0;
        if (push_s && (!full_s || pop_s)) begin
            wr_en_s      = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else if (push_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Queue pointers, occupancy and sticky overflow (a drop beats a clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            atn_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            atn_r    <= (level_nxt_s != '0);
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Entry storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            mem_r[wr_ptr_r[PW-2:0]] <= {addr_lat_r, kind_lat_r, dir_lat_r, d_q_r};
        end
    end

    // Word offered to the Pi, sampled only on the IDLE to ACK transition.
    always_comb begin
        pi_word_s = 16'hFFFF;
        if (bus.pi_sel) begin
            pi_word_s = status_word(head_s[9:0], ovf_r, empty_s);
        end else if (empty_s) begin
            pi_word_s = 16'hFFFF;
        end else begin
            pi_word_s = head_s[25:10];
        end
    end

    // Handshake next-state; the pop waits until DONE so a read is never lost mid-transfer.
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.pi_req) begin
                    state_nxt_s = ST_ACK;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!bus.pi_req) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACK;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                pop_s       = lat_sel_r && lat_nonempty_r && !empty_s;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake state, registered acknowledge and latched word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            pi_ack_r       <= 1'b0;
            pi_data_r      <= 16'hFFFF;
            lat_sel_r      <= 1'b0;
            lat_nonempty_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pi_ack_r <= (state_nxt_s == ST_ACK);
            if (latch_s) begin
                pi_data_r      <= pi_word_s;
                lat_sel_r      <= bus.pi_sel;
                lat_nonempty_r <= !empty_s;
            end else begin
                pi_data_r      <= pi_data_r;
                lat_sel_r      <= lat_sel_r;
                lat_nonempty_r <= lat_nonempty_r;
            end
        end
    end

    assign bus.pi_data = pi_data_r;
    assign bus.pi_ack  = pi_ack_r;
    assign bus.atn     = atn_r;
    assign bus.level   = level_r;
endmodule

// File: tb/tb_msx_bus_event_fifo.sv
// Self-checking bench for msx_bus_event_fifo: directed vectors, corner sequences
// and random traffic against a queue-based reference model.
module tb_msx_bus_event_fifo;
    localparam int DLOG  = 4;
    localparam int DEPTH = 1 << DLOG;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    msx_bus_event_fifo_if #(.DEPTH_LOG2(DLOG)) bus ();

    msx_bus_event_fifo #(.DEPTH_LOG2(DLOG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        kind;
        logic        dir;
        logic [7:0]  data;
    } ev_t;

    ev_t  mq[$];
    logic m_ovf;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        sltsl;
        logic        mreq;
        logic        iorq;
        logic        is_rd;
        int          low;
        int          exp_level;
        logic [15:0] exp_w0;
        logic [15:0] exp_w1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input logic sel);
        ev_t e;
        if (mq.size() == 0) begin
            if (!sel) return 16'hFFFF;
            return m_ovf ? 16'h30FF : 16'h10FF;
        end
        e = mq[0];
        if (!sel) return e.addr;
        return {e.dir, e.kind, m_ovf, 1'b0, 4'h0, e.data};
    endfunction

    // One bus cycle; called and returning at a negedge.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic sltsl,
                             input logic mreq, input logic iorq, input logic is_rd, input int low);
        logic hit;
        ev_t  e;
        bus.a = a; bus.d_in = d;
        bus.sltsl = sltsl; bus.mreq = mreq; bus.iorq = iorq;
        bus.rd = !is_rd; bus.wr = is_rd;
        repeat (low) @(negedge clk);
        bus.rd = 1'b1; bus.wr = 1'b1;
        bus.sltsl = 1'b1; bus.mreq = 1'b1; bus.iorq = 1'b1;
        bus.d_in = ~d; bus.a = ~a;
        hit = (!sltsl && !mreq) || !iorq;
        @(negedge clk);
        if (hit) begin
            if (mq.size() < DEPTH) begin
                e.addr = a; e.kind = !iorq; e.dir = is_rd; e.data = d;
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        chk("bus_level", bus.level, mq.size());
        chk("bus_atn", bus.atn, mq.size() != 0);
    endtask

    task automatic pi_read(input logic sel, output logic [15:0] w);
        int n;
        bus.pi_sel = sel;
        bus.pi_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.pi_ack && n < 8);
        chk("ack_rise_lat", n, 1);
        w = bus.pi_data;
        bus.pi_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.pi_ack && n < 8);
        chk("ack_fall_lat", n, 1);
        @(negedge clk);
    endtask

    task automatic read_check(input logic sel, input string name);
        logic [15:0] exp_w;
        logic [15:0] w;
        exp_w = model_word(sel);
        pi_read(sel, w);
        chk(name, w, exp_w);
        if (sel && mq.size() != 0) void'(mq.pop_front());
        chk("read_level", bus.level, mq.size());
    endtask

    task automatic ovf_pulse();
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [15:0] exp_w;
        ev_t         e;
        int          r;
        logic        s, m, io;

        vecs[0] = '{16'h4123, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1, 16'h4123, 16'h00A5};
        vecs[1] = '{16'h0098, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 16'h0098, 16'hC03C};
        vecs[2] = '{16'h8000, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1, 16'h8000, 16'h805A};
        vecs[3] = '{16'h00FF, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 16'h00FF, 16'h4001};
        vecs[4] = '{16'h1234, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 16'hFFFF, 16'h10FF};
        vecs[5] = '{16'h5555, 8'h66, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 16'hFFFF, 16'h10FF};

        m_ovf = 1'b0;
        reset = 1'b1;
        bus.a = 16'h0000; bus.d_in = 8'h00;
        bus.rd = 1'b1; bus.wr = 1'b1; bus.mreq = 1'b1; bus.iorq = 1'b1; bus.sltsl = 1'b1;
        bus.pi_req = 1'b0; bus.pi_sel = 1'b0; bus.ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pi_data", bus.pi_data, 16'hFFFF);
        chk("rst_pi_ack", bus.pi_ack, 1'b0);
        chk("rst_atn", bus.atn, 1'b0);
        chk("rst_level", bus.level, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, each drained back to empty
        for (int i = 0; i < 6; i++) begin
            bus_cycle(vecs[i].a, vecs[i].d, vecs[i].sltsl, vecs[i].mreq, vecs[i].iorq,
                      vecs[i].is_rd, vecs[i].low);
            chk("vec_level", bus.level, vecs[i].exp_level);
            pi_read(1'b0, w);
            chk("vec_word0", w, vecs[i].exp_w0);
            chk("vec_level_sel0", bus.level, vecs[i].exp_level);
            pi_read(1'b1, w);
            chk("vec_word1", w, vecs[i].exp_w1);
            if (mq.size() != 0) void'(mq.pop_front());
            chk("vec_level_pop", bus.level, 0);
        end

        // Fill past capacity: 17th is dropped, ovf sticks
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus_cycle(16'h6000 + 16'(i), 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1);
        end
        chk("fill_level", bus.level, DEPTH);
        read_check(1'b0, "fill_head_addr");
        for (int i = 0; i < DEPTH; i++) begin
            read_check(1'b1, "drain_word");
        end
        pi_read(1'b1, w);
        chk("empty_ovf_word", w, 16'h30FF);
        ovf_pulse();
        pi_read(1'b1, w);
        chk("empty_clr_word", w, 16'h10FF);

        // Full queue: bus-cycle end coincides with the pop
        for (int i = 0; i < DEPTH; i++) begin
            bus_cycle(16'h0100 + 16'(i), 8'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1);
        end
        bus.a = 16'hBEEF; bus.d_in = 8'h42;
        bus.sltsl = 1'b0; bus.mreq = 1'b0; bus.iorq = 1'b1; bus.wr = 1'b0; bus.rd = 1'b1;
        bus.pi_sel = 1'b1; bus.pi_req = 1'b1;
        @(negedge clk);
        chk("sim_ack", bus.pi_ack, 1'b1);
        exp_w = model_word(1'b1);
        chk("sim_word", bus.pi_data, exp_w);
        bus.pi_req = 1'b0;
        @(negedge clk);
        chk("sim_ack_fall", bus.pi_ack, 1'b0);
        bus.wr = 1'b1; bus.sltsl = 1'b1; bus.mreq = 1'b1; bus.d_in = 8'h00;
        @(negedge clk);
        void'(mq.pop_front());
        e.addr = 16'hBEEF; e.kind = 1'b0; e.dir = 1'b0; e.data = 8'h42;
        mq.push_back(e);
        chk("sim_level", bus.level, DEPTH);
        chk("sim_atn", bus.atn, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            read_check(1'b0, "sim_drain_addr");
            read_check(1'b1, "sim_drain_word");
        end

        // Reset in the middle of a handshake
        bus_cycle(16'h4000, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        bus_cycle(16'h4001, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        bus.pi_sel = 1'b0; bus.pi_req = 1'b1;
        @(negedge clk);
        chk("mid_ack", bus.pi_ack, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", bus.pi_ack, 1'b0);
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_atn", bus.atn, 1'b0);
        chk("mid_rst_data", bus.pi_data, 16'hFFFF);
        reset = 1'b0; bus.pi_req = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        read_check(1'b1, "post_rst_word");

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                r = $urandom_range(0, 9);
                if (r < 4) begin
                    s = 1'b0; m = 1'b0; io = 1'b1;
                end else if (r < 8) begin
                    s = 1'b1; m = 1'b1; io = 1'b0;
                end else begin
                    s = 1'b1; m = 1'($urandom_range(0, 1)); io = 1'b1;
                end
                bus_cycle(16'($urandom), 8'($urandom), s, m, io,
                          1'($urandom_range(0, 1)), $urandom_range(1, 3));
            end else if (r < 9) begin
                read_check(1'($urandom_range(0, 1)), "rand_word");
            end else begin
                ovf_pulse();
            end
        end
        while (mq.size() != 0) begin
            read_check(1'b1, "final_drain");
        end
        read_check(1'b1, "final_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
